// File: rtl/chip_vector_tester.sv
// Vector-driven pin tester: drives each stored vector onto the pads, waits SETTLE
// cycles, then compares synchronised pin levels against the expected value under mask.
module chip_vector_tester #(
  parameter int NPINS  = 16,
  parameter int DEPTH  = 32,
  parameter int SETTLE = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_fail,
  input  logic [AW:0]      num_vec,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [NPINS-1:0] ld_oe,
  input  logic [NPINS-1:0] ld_drive,
  input  logic [NPINS-1:0] ld_expect,
  input  logic [NPINS-1:0] ld_care,
  input  logic [NPINS-1:0] pin_in,
  output logic [NPINS-1:0] pin_oe,
  output logic [NPINS-1:0] pin_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW-1:0]    fail_idx,
  output logic [NPINS-1:0] fail_pins,
  output logic [AW:0]      err_count
);

  localparam int CW = $clog2(SETTLE);
  localparam logic [AW:0]   DEPTH_E = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_E   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] CNT_END = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  logic [NPINS-1:0] mem_oe     [DEPTH];
  logic [NPINS-1:0] mem_drive  [DEPTH];
  logic [NPINS-1:0] mem_expect [DEPTH];
  logic [NPINS-1:0] mem_care   [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW:0]      n_q, n_d;
  logic             stop_q, stop_d;
  logic [NPINS-1:0] pin_oe_q, pin_oe_d;
  logic [NPINS-1:0] pin_out_q, pin_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [AW-1:0]    fail_idx_q, fail_idx_d;
  logic [NPINS-1:0] fail_pins_q, fail_pins_d;
  logic [AW:0]      err_q, err_d;
  logic [NPINS-1:0] sync1_q, sync1_d;
  logic [NPINS-1:0] sync2_q, sync2_d;

  logic [AW:0]      n_eff;
  logic [AW-1:0]    idx_nx;
  logic [NPINS-1:0] mism;
  logic             last;
  logic [AW:0]      err_inc;

  // Loads are locked out for the whole run so the vector under test never changes.
  always_ff @(posedge clk) begin
    if (ld_en && !busy_q) begin
      mem_oe[ld_addr]     <= ld_oe;
      mem_drive[ld_addr]  <= ld_drive;
      mem_expect[ld_addr] <= ld_expect;
      mem_care[ld_addr]   <= ld_care;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    stop_d      = stop_q;
    pin_oe_d    = pin_oe_q;
    pin_out_d   = pin_out_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_idx_d  = fail_idx_q;
    fail_pins_d = fail_pins_q;
    err_d       = err_q;
    sync1_d     = pin_in;
    sync2_d     = sync1_q;

    n_eff   = (num_vec > DEPTH_E) ? DEPTH_E : num_vec;
    idx_nx  = idx_q + ONE_A;
    mism    = (sync2_q ^ mem_expect[idx_q]) & mem_care[idx_q] & ~mem_oe[idx_q];
    last    = (({1'b0, idx_q} + ONE_E) == n_q);
    err_inc = (err_q == '1) ? err_q : err_q + ONE_E;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d       = '0;
          cnt_d       = '0;
          n_d         = n_eff;
          stop_d      = stop_on_fail;
          err_d       = '0;
          fail_idx_d  = '0;
          fail_pins_d = '0;
          pass_d      = 1'b0;
          if (n_eff == '0) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b1;
            pin_oe_d  = '0;
            pin_out_d = '0;
          end else begin
            state_d   = S_DRIVE;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pin_oe_d  = mem_oe['0];
            pin_out_d = mem_drive['0];
          end
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == CNT_END) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (|mism) begin
          err_d = err_inc;
          // A saturating count never returns to zero, so zero means no earlier failure.
          if (err_q == '0) begin
            fail_idx_d  = idx_q;
            fail_pins_d = mism;
          end
        end
        if (last || ((|mism) && stop_q)) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (err_d == '0);
          pin_oe_d  = '0;
          pin_out_d = '0;
        end else begin
          state_d   = S_DRIVE;
          idx_d     = idx_nx;
          cnt_d     = '0;
          pin_oe_d  = mem_oe[idx_nx];
          pin_out_d = mem_drive[idx_nx];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      stop_q      <= 1'b0;
      pin_oe_q    <= '0;
      pin_out_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_idx_q  <= '0;
      fail_pins_q <= '0;
      err_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      stop_q      <= stop_d;
      pin_oe_q    <= pin_oe_d;
      pin_out_q   <= pin_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_idx_q  <= fail_idx_d;
      fail_pins_q <= fail_pins_d;
      err_q       <= err_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

  assign pin_oe    = pin_oe_q;
  assign pin_out   = pin_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_idx  = fail_idx_q;
  assign fail_pins = fail_pins_q;
  assign err_count = err_q;

endmodule
